// File: rtl/pipe_pkg.sv
// pipe_pkg: default widths and control-field bit positions shared by the pipeline registers.
// Revision 1.0
`default_nettype none

package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_WB_W   = 2;
  localparam int DEF_M_W    = 3;

  // Bit positions within the WB and M control fields
  localparam int WB_REGWRITE_BIT = 0;
  localparam int WB_MEMTOREG_BIT = 1;
  localparam int M_BRANCH_BIT    = 0;
  localparam int M_MEMREAD_BIT   = 1;
  localparam int M_MEMWRITE_BIT  = 2;

endpackage

`default_nettype wire

// File: rtl/ex_mem_skid_if.sv
// ex_mem_skid_if: EX->MEM handshake and payload bundle; slave = pipeline register, master = driver.
// Revision 1.0
`default_nettype none

interface ex_mem_skid_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int WB_W   = DEF_WB_W,
  parameter int M_W    = DEF_M_W
);

  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [WB_W-1:0]   WB;
  logic [M_W-1:0]    M;
  logic [DATA_W-1:0] ALUOut;
  logic [DATA_W-1:0] WriteDataIn;
  logic [REG_W-1:0]  RegRD;
  logic              out_valid;
  logic              out_ready;
  logic [WB_W-1:0]   WBreg;
  logic [M_W-1:0]    Mreg;
  logic [DATA_W-1:0] ALUreg;
  logic [DATA_W-1:0] WriteDataOut;
  logic [REG_W-1:0]  RegRDreg;

  modport slave (
    input  in_valid, flush, WB, M, ALUOut, WriteDataIn, RegRD, out_ready,
    output in_ready, out_valid, WBreg, Mreg, ALUreg, WriteDataOut, RegRDreg
  );

  modport master (
    output in_valid, flush, WB, M, ALUOut, WriteDataIn, RegRD, out_ready,
    input  in_ready, out_valid, WBreg, Mreg, ALUreg, WriteDataOut, RegRDreg
  );

endinterface

`default_nettype wire

// File: rtl/pipe_slot.sv
// pipe_slot: one pipeline entry (valid bit plus payload) with load enable and valid clear.
// Revision 1.0
`default_nettype none

module pipe_slot #(
  parameter int W = 8
) (
  input  wire logic         clock,
  input  wire logic         reset,
  input  wire logic         i_load,
  input  wire logic         i_clear,
  input  wire logic [W-1:0] i_data,
  output logic              o_valid,
  output logic [W-1:0]      o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Clear drops only the valid bit; payload keeps its last loaded value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_clear) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX/MEM pipeline register with a two-entry skid buffer and registered in_ready.
// Revision 1.0
`default_nettype none

module ex_mem_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int WB_W   = DEF_WB_W,
  parameter int M_W    = DEF_M_W
) (
  input wire logic      clock,
  input wire logic      reset,
  ex_mem_skid_if.slave  bus
);

  localparam int PAY_W = WB_W + M_W + 2*DATA_W + REG_W;

  logic             w_main_valid, w_skid_valid;
  logic [PAY_W-1:0] w_main_data, w_skid_data, w_in_data, w_main_din;
  logic             w_accept, w_release;
  logic             w_main_load, w_main_clear, w_skid_load, w_skid_clear;

  logic [WB_W-1:0]   w_wb;
  logic [M_W-1:0]    w_m;
  logic [DATA_W-1:0] w_alu, w_wd;
  logic [REG_W-1:0]  w_rd;

  assign w_in_data = {bus.WB, bus.M, bus.ALUOut, bus.WriteDataIn, bus.RegRD};
  assign w_accept  = bus.in_valid && !w_skid_valid;
  assign w_release = w_main_valid && bus.out_ready;

  always_comb begin
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    w_main_din   = w_skid_valid ? w_skid_data : w_in_data;
    if (bus.flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else if (w_skid_valid) begin
      // Skid full means no accept is possible; release promotes skid to main
      if (w_release) begin
        w_main_load  = 1'b1;
        w_skid_clear = 1'b1;
      end
    end else if (w_accept) begin
      if (!w_main_valid || w_release) w_main_load = 1'b1;
      else                            w_skid_load = 1'b1;
    end else if (w_release) begin
      w_main_clear = 1'b1;
    end
  end

  pipe_slot #(.W(PAY_W)) u_main (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_din),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  pipe_slot #(.W(PAY_W)) u_skid (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (w_in_data),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  assign {w_wb, w_m, w_alu, w_wd, w_rd} = w_main_data;

  // Control fields are gated so a bubble can never write memory or the register file
  assign bus.in_ready     = !w_skid_valid;
  assign bus.out_valid    = w_main_valid;
  assign bus.WBreg        = w_main_valid ? w_wb : '0;
  assign bus.Mreg         = w_main_valid ? w_m  : '0;
  assign bus.ALUreg       = w_alu;
  assign bus.WriteDataOut = w_wd;
  assign bus.RegRDreg     = w_rd;

endmodule

`default_nettype wire

// File: doc/ex_mem_skid.md
EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 Parameter DATA_W, default 32, ALU result and store-data width.
REQ-002 Parameter REG_W, default 5, destination register index width.
REQ-003 Parameter WB_W, default 2, write-back control width.
REQ-004 Parameter M_W, default 3, memory control width.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  EX stage presents a valid instruction.
REQ-008 in_ready  output  1  block can accept an instruction this cycle.
REQ-009 flush  input  1  synchronous squash of all held instructions.
REQ-010 WB  input  WB_W  write-back control from EX.
REQ-011 M  input  M_W  memory control from EX.
REQ-012 ALUOut  input  DATA_W  ALU result.
REQ-013 WriteDataIn  input  DATA_W  store data.
REQ-014 RegRD  input  REG_W  destination register.
REQ-015 out_valid  output  1  MEM stage is presented a valid instruction.
REQ-016 out_ready  input  1  MEM stage accepts the instruction this cycle.
REQ-017 WBreg, Mreg, ALUreg, WriteDataOut, RegRDreg  output  WB_W/M_W/DATA_W/DATA_W/REG_W  registered copies to MEM.

Function
REQ-018 The block SHALL hold two entries, main (drives outputs) and skid, each holding a valid bit plus all payload fields.
REQ-019 Accept SHALL occur on an edge where in_valid=1 and in_ready=1; release SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-020 in_ready SHALL equal NOT skid.valid, from a register, with no combinational path from out_ready.
REQ-021 out_valid SHALL equal main.valid.
REQ-022 Latency from accept into an empty block to out_valid=1 SHALL be exactly one cycle.
REQ-023 Accept with main empty, or with main released in the same cycle and skid empty, SHALL load main.
REQ-024 Accept with main full and not released SHALL load skid.
REQ-025 Release with skid full SHALL move skid to main on that edge and clear skid.valid.
REQ-026 Continuous in_valid=1 and out_ready=1 SHALL sustain one transfer per cycle with no bubbles.
REQ-027 Entries SHALL retain unmodified payload while out_ready=0; ordering SHALL be strictly FIFO.
REQ-028 WBreg and Mreg SHALL read zero whenever out_valid=0, so that a bubble never writes memory or registers.
REQ-029 ALUreg, WriteDataOut and RegRDreg SHALL hold their last loaded value while out_valid=0.
REQ-030 flush=1 SHALL clear both valid bits on the next edge, discard any simultaneous accept, and override release.
REQ-031 in_ready SHALL be 1 in the cycle after a flush.

Reset
REQ-032 Assertion of reset SHALL immediately clear both valid bits and all payload registers to zero, asynchronously to clock.
REQ-033 During reset and afterwards, out_valid=0, in_ready=1 and all data outputs=0 SHALL hold until the first accept.
REQ-034 Reset asserted mid-stall SHALL discard both entries; no held instruction reappears after deassertion.

Structure
REQ-035 Default widths and control-field bit positions SHALL reside in shared package pipe_pkg, which all pipeline registers use.
REQ-036 One entry SHALL be a sub-module pipe_slot (valid plus payload, load enable, clear), instantiated twice.

Verification
REQ-037 Reset, then accept ALUOut=0x0000_0010, RegRD=5, M=3'b010, with out_ready=1 -> next cycle out_valid=1, ALUreg=0x10, RegRDreg=5, Mreg=3'b010; the following cycle out_valid=0 and Mreg=0.
REQ-038 Stream ALUOut=1,2,3,4 on consecutive cycles with out_ready=1 -> outputs 1,2,3,4 on consecutive cycles, in_ready constantly 1.
REQ-039 Hold out_ready=0 and offer 1,2,3 -> 1 in main, 2 in skid, in_ready=0, 3 held by the source; raising out_ready then yields 1,2,3 in order.
REQ-040 With both entries full, pulse flush together with in_valid=1 (ALUOut=9) -> next cycle out_valid=0, WBreg=0, Mreg=0, in_ready=1; 9 never appears at the output.
REQ-041 Assert reset between edges while stalled with two entries -> outputs go to zero before the next edge; after deassertion out_valid stays 0 until a new accept.
REQ-042 Randomised in_valid/out_ready over 10k cycles against a FIFO model -> no loss, duplication or reordering, and Mreg=0 whenever out_valid=0.
